// File: rtl/ring_pulse_sequencer.sv
// One-hot ring sequencer: rotates a ring and emits a bounded burst of tap pulses, always parking the ring at bit 0.
// Optional ring-integrity checker is built when RING_SEQ_CHECK_EN is defined.
module ring_pulse_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [$clog2(WIDTH)-1:0] tap_sel,
    input  logic [CNT_W-1:0]         burst_len,
    output logic                     busy,
    output logic                     done,
    output logic                     pulse_out,
    output logic [WIDTH-1:0]         ring_q,
    output logic [CNT_W-1:0]         pulse_count,
    output logic                     err
);
    localparam int TW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] ring, ring_nxt, ring_rot;
    logic [TW-1:0]    tap;
    logic [CNT_W-1:0] len, count;
    logic             done_r, exit_seq, accept, last_pulse, finish;

    // Non-power-of-two rings can be addressed past their end; pin those to the top bit.
    function automatic logic [TW-1:0] clamp_tap(input logic [TW-1:0] t);
        if (32'(t) > 32'(WIDTH - 1))
            return TW'(WIDTH - 1);
        return t;
    endfunction

    assign ring_rot    = {ring[WIDTH-2:0], ring[WIDTH-1]};
    assign accept      = (state == IDLE) && start;
    assign pulse_out   = (state == RUN) && ring[tap];
    assign last_pulse  = pulse_out && (len != '0) && ((count + CNT_W'(1)) == len);
    assign finish      = last_pulse || stop;
    assign busy        = (state != IDLE);
    assign done        = done_r;
    assign ring_q      = ring;
    assign pulse_count = count;

`ifdef RING_SEQ_CHECK_EN
    logic corrupt;
    assign corrupt = busy && ($countones(ring) != 1);
`endif

    always_comb begin
        state_nxt = state;
        ring_nxt  = ring;
        exit_seq  = 1'b0;
        case (state)
            IDLE: begin
                if (start)
                    state_nxt = RUN;
            end
            RUN: begin
                ring_nxt = ring_rot;
                // Leaving on the top bit means the rotation lands the ring back at home.
                if (finish) begin
                    if (ring[WIDTH-1]) begin
                        state_nxt = IDLE;
                        exit_seq  = 1'b1;
                    end else begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                ring_nxt = ring_rot;
                if (ring[WIDTH-1]) begin
                    state_nxt = IDLE;
                    exit_seq  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
`ifdef RING_SEQ_CHECK_EN
        if (corrupt) begin
            state_nxt = IDLE;
            ring_nxt  = WIDTH'(1);
            exit_seq  = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ring   <= WIDTH'(1);
            tap    <= '0;
            len    <= '0;
            count  <= '0;
            done_r <= 1'b0;
        end else begin
            state  <= state_nxt;
            ring   <= ring_nxt;
            done_r <= exit_seq;
            if (accept) begin
                tap   <= clamp_tap(tap_sel);
                len   <= burst_len;
                count <= '0;
            end else if (pulse_out && (count != '1)) begin
                count <= count + CNT_W'(1);
            end
        end
    end

`ifdef RING_SEQ_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err <= 1'b0;
        else if (corrupt)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ring_pulse_sequencer.sv
// Directed bench for ring_pulse_sequencer (WIDTH=16, CNT_W=8): vector table of bursts plus reset and checker sequences.
module tb_ring_pulse_sequencer;
    localparam int W = 16;

    logic       clk = 1'b0;
    logic       rst_n, start, stop;
    logic [3:0] tap_sel;
    logic [7:0] burst_len;
    logic       busy, done, pulse_out, err;
    logic [15:0] ring_q;
    logic [7:0] pulse_count;

    int n_cmp = 0;
    int n_fail = 0;
    int exp_err = 0;

    ring_pulse_sequencer #(.WIDTH(W), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
        .tap_sel(tap_sel), .burst_len(burst_len),
        .busy(busy), .done(done), .pulse_out(pulse_out),
        .ring_q(ring_q), .pulse_count(pulse_count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int tap_raw;
        int len;
        int stop_cyc;
        int start_stop;
        int restart_cyc;
        int exp_np;
        int exp_done;
        int exp_cnt;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Starts at a falling edge; returns at the falling edge of the done cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int pc[$];
        int c, eff, bad_act, bad_exp, lag_act, lag_exp;
        bit got_done, pos_bad, lag_bad;
        eff = (v.tap_raw > W - 1) ? W - 1 : v.tap_raw;
        tap_sel = 4'(v.tap_raw);
        burst_len = 8'(v.len);
        start = 1'b1;
        stop = v.start_stop[0];
        @(posedge clk); #1;
        start = 1'b0;
        stop = 1'b0;
        c = 0; got_done = 0; lag_bad = 0; lag_act = 0; lag_exp = 0;
        while (c < 6000) begin
            stop = (c == v.stop_cyc);
            if (c == v.restart_cyc) begin
                start = 1'b1; tap_sel = 4'd2; burst_len = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done) begin
                got_done = 1;
                break;
            end
            if (pulse_out) begin
                if (!lag_bad && pulse_count != 8'((pc.size() > 255) ? 255 : pc.size())) begin
                    lag_bad = 1; lag_act = pulse_count; lag_exp = (pc.size() > 255) ? 255 : pc.size();
                end
                pc.push_back(c);
            end
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        stop = 1'b0;
        check($sformatf("v%0d done_seen", idx), int'(got_done), 1);
        check($sformatf("v%0d done_cycle", idx), c, v.exp_done);
        check($sformatf("v%0d num_pulses", idx), pc.size(), v.exp_np);
        pos_bad = 0; bad_act = 0; bad_exp = 0;
        foreach (pc[k]) begin
            if (!pos_bad && pc[k] != eff + k * W) begin
                pos_bad = 1; bad_act = pc[k]; bad_exp = eff + k * W;
            end
        end
        check($sformatf("v%0d pulse_cycle", idx), bad_act, bad_exp);
        check($sformatf("v%0d count_lag", idx), lag_act, lag_exp);
        check($sformatf("v%0d pulse_count", idx), int'(pulse_count), v.exp_cnt);
        check($sformatf("v%0d ring_home", idx), int'(ring_q), 1);
        check($sformatf("v%0d busy_at_done", idx), int'(busy), 0);
        check($sformatf("v%0d err", idx), int'(err), exp_err);
    endtask

    initial begin
        vecs[0]  = '{9,  3, -1,   0, -1, 3,   48,   3};
        vecs[1]  = '{15, 1, -1,   0, -1, 1,   16,   1};
        vecs[2]  = '{0,  1, -1,   0, -1, 1,   16,   1};
        vecs[3]  = '{9,  0, 20,   0, -1, 1,   32,   1};
        vecs[4]  = '{9,  0, 25,   0, -1, 2,   32,   2};
        vecs[5]  = '{31, 2, -1,   0, -1, 2,   32,   2};
        vecs[6]  = '{3,  0, 15,   0, -1, 1,   16,   1};
        vecs[7]  = '{5,  2, 5,    0, -1, 1,   16,   1};
        vecs[8]  = '{2,  1, -1,   1, -1, 1,   16,   1};
        vecs[9]  = '{9,  1, -1,   0, 5,  1,   16,   1};
        vecs[10] = '{0,  0, 40,   0, -1, 3,   48,   3};
        vecs[11] = '{0,  0, 4175, 0, -1, 261, 4176, 255};
        vecs[12] = '{7,  4, -1,   0, -1, 4,   64,   4};

        rst_n = 1'b0; start = 1'b0; stop = 1'b0; tap_sel = '0; burst_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst ring_q", int'(ring_q), 1);
        check("rst busy", int'(busy), 0);
        check("rst done", int'(done), 0);
        check("rst pulse_count", int'(pulse_count), 0);
        check("rst pulse_out", int'(pulse_out), 0);
        check("rst err", int'(err), 0);

        // Table vectors chain back-to-back: each start lands in the previous done cycle.
        for (int i = 0; i < 13; i++)
            run_vec(vecs[i], i);

        // Asynchronous reset mid-burst.
        tap_sel = 4'd9; burst_len = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("midrst count_before", int'(pulse_count), 2);
        check("midrst busy_before", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check("midrst ring_q", int'(ring_q), 1);
        check("midrst busy", int'(busy), 0);
        check("midrst pulse_count", int'(pulse_count), 0);
        check("midrst done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (20) begin
                @(negedge clk);
                if (done || busy) seen = 1;
            end
            check("midrst quiet_after", seen, 0);
        end

`ifdef RING_SEQ_CHECK_EN
        tap_sel = 4'd9; burst_len = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(negedge clk);
        force dut.ring = 16'h0011;
        #1;
        release dut.ring;
        @(negedge clk);
        check("chk err_set", int'(err), 1);
        check("chk ring_home", int'(ring_q), 1);
        check("chk busy", int'(busy), 0);
        check("chk done", int'(done), 0);
        @(negedge clk);
        check("chk done_later", int'(done), 0);
        check("chk err_sticky", int'(err), 1);
        exp_err = 1;
        run_vec(vecs[0], 100);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/ring_pulse_sequencer.md
# ring_pulse_sequencer

Controller that owns a one-hot rotating ring register and sequences it into bounded bursts of tap pulses. A requester loads a tap position and a pulse count and issues `start`. The block rotates the ring, emits one `pulse_out` per revolution at the selected tap, and returns the ring to its home state (bit 0 set) before signalling `done`. It sits between the control logic and the downstream timing consumers that previously read a fixed ring tap directly.

## Interface
- `WIDTH`, default 16: ring length in bits; must be ≥ 2.
- `CNT_W`, default 8: width of the burst length and pulse counter.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  single-cycle request; sampled only in IDLE.
- `stop`  input  1  early-termination request; sampled only in RUN.
- `tap_sel`  input  $clog2(WIDTH)  ring bit that generates pulses; latched on accepted `start`.
- `burst_len`  input  CNT_W  number of pulses to emit; 0 means continuous until `stop`; latched on accepted `start`.
- `busy`  output  1  high in RUN and DRAIN.
- `done`  output  1  one-cycle pulse in the first IDLE cycle after a sequence completes.
- `pulse_out`  output  1  tap pulse, combinational from ring state and FSM state.
- `ring_q`  output  WIDTH  current ring contents.
- `pulse_count`  output  CNT_W  number of pulses emitted in the current or last burst.
- `err`  output  1  sticky ring-integrity error; exists only with the macro, otherwise tied 0.

## Operation
- Reset values:
  - `ring_q` = 1 (bit 0 only).
  - State = IDLE.
  - `busy`, `done`, `pulse_out`, `pulse_count`, `err` = 0.
  - Latched tap and latched burst length = 0.
- Reset asserted mid-sequence aborts immediately to these values; no `done` is issued.
- States: IDLE, RUN, DRAIN.
- **IDLE**
  - Ring holds at 1.
  - `start` = 1 latches the tap and burst length, clears `pulse_count`, and moves to RUN.
  - `stop` is ignored. When `start` and `stop` arrive together, `start` is accepted and `stop` is ignored.
- **RUN**
  - The ring rotates left by one bit every cycle: bit WIDTH-1 moves to bit 0.
  - `pulse_out` = `ring_q`[tap] & (state == RUN).
  - Each cycle with `pulse_out` = 1 increments `pulse_count` at the next edge.
  - The counter saturates at its maximum value in continuous mode.
  - Leave RUN when the final pulse is emitted (count + 1 == `burst_len`, with `burst_len` ≠ 0), or when `stop` is sampled.
- **DRAIN**
  - The ring keeps rotating; `pulse_out` is forced to 0.
- **Exit to IDLE**
  - Occurs in RUN or DRAIN when `ring_q`[WIDTH-1] = 1 and the sequence is finished (budget exhausted, including this cycle's pulse, or stop already taken).
  - At that edge the ring rotates to 1, the state becomes IDLE, and `done` = 1 for exactly one cycle.
  - If the finishing condition and `ring_q`[WIDTH-1] = 1 coincide in RUN, go straight to IDLE without visiting DRAIN.
- `stop` in the same cycle as a pulse: that pulse is emitted and counted, then the FSM drains.
- `tap_sel` ≥ WIDTH is clamped to WIDTH-1 at the latch.
- `start` while `busy` is ignored; latched values do not change.

## Timing
- Label the first RUN cycle as cycle 0 (one cycle after `start` is sampled); `ring_q` = 1 in cycle 0.
- Pulse k (k starting at 0) is high during cycle tap + k·WIDTH.
- With `burst_len` = N ≠ 0 and no stop: `done` is high in cycle N·WIDTH and `busy` falls in that same cycle. This holds independent of the tap.
- With `stop` sampled in cycle s: `done` is high in cycle WIDTH·(floor(s/WIDTH)+1).
- `pulse_count` updates one cycle after the pulse it counts.
- A new `start` is accepted in the same cycle that `done` is high.

## Configuration
- Macro: `RING_SEQ_CHECK_EN`.
- **Defined:** while `busy`, if the population count of `ring_q` ≠ 1:
  - `err` is set (sticky until reset);
  - the ring is forced to 1 and the state to IDLE at the next edge;
  - `done` is not asserted.
  - `err` does not block later `start` requests.
- **Undefined:** no checker logic; `err` is a constant 0 and a corrupted ring rotates as-is.

## Test plan
- Reset defaults: hold `rst_n` low, then release -> `ring_q` = 0x0001, `busy` = 0, `done` = 0, `pulse_count` = 0.
- Basic burst: WIDTH = 16, `tap_sel` = 9, `burst_len` = 3, pulse `start` -> pulses in cycles 9, 25, 41; `done` in cycle 48; `pulse_count` = 3; `ring_q` = 0x0001.
- Boundary taps:
  - `tap_sel` = 15, `burst_len` = 1 -> single pulse in cycle 15 and `done` in cycle 16, with no DRAIN state entered.
  - `tap_sel` = 0 -> pulse in cycle 0.
- Early stop: `burst_len` = 0, `stop` in cycle 20 -> pulses in cycles 9 only (20 is not a tap cycle), `done` in cycle 32, `pulse_count` = 1.
  - Repeat with `stop` in cycle 25 -> that pulse is counted, `pulse_count` = 2.
- Protocol edges:
  - `start` while busy -> ignored;
  - `start` together with `stop` in IDLE -> sequence starts;
  - `tap_sel` = 31 with WIDTH = 16 -> behaves as tap 15;
  - `rst_n` low in cycle 30 -> immediate reset values, no `done`.
- Macro enabled: force `ring_q` to 0x0011 during RUN -> `err` = 1 and sticky, `ring_q` = 0x0001, state IDLE, no `done`. Next `start` runs normally.
